imem_boot_loader: RTL and testbench

//  Upstream of Pipeline_top. Receives a byte-stream program image and writes it word-by-word into
//  the instruction-memory write port. Holds the core in reset until the image is loaded and the

---
 rtl/imem_boot_loader.sv | 103 ++++++++++
 tb/tb_imem_boot_loader.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads a byte-stream program image into instruction memory, then releases the core
//   clk, rst_n       clock, asynchronous active-low reset
//   s_valid_i/s_data_i/s_ready_o   byte stream in (transfer = valid & ready)
//   imem_we_o/imem_addr_o/imem_wdata_o   one-cycle imem word write
//   core_rst_o       active-low core reset (high once image verified)
//   done_o/err_o     sticky load success / failure
//   words_ld_o       words written so far
module imem_boot_loader #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid_i,
  input  logic [7:0]        s_data_i,
  output logic              s_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              core_rst_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W:0]   words_ld_o
);
  typedef enum logic [2:0] {IDLE, HDR, DATA, CSUM, DONE, ERR} state_t;
  state_t              state_q, state_d;
  logic [1:0]          bcnt_q, bcnt_d;
  logic [31:0]         n_q, n_d, sh_q, sh_d, wdata_q, wdata_d, shifted;
  logic [7:0]          csum_q, csum_d;
  logic                we_q, we_d, done_q, done_d, err_q, err_d, acc;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     wl_q, wl_d;
  assign s_ready_o    = state_q inside {HDR, DATA, CSUM};
  assign acc          = s_valid_i & s_ready_o;
  // header and payload words share one shift register; byte0 ends up in bits [7:0]
  assign shifted      = {s_data_i, sh_q[31:8]};
  assign imem_we_o    = we_q;
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = wdata_q;
  assign core_rst_o   = done_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign words_ld_o   = wl_q;
  always_comb begin
    state_d = state_q;
    bcnt_d  = acc ? bcnt_q + 2'd1 : bcnt_q;
    sh_d    = acc ? shifted : sh_q;
    n_d     = n_q;
    csum_d  = csum_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wl_d    = wl_q;
    case (state_q)
      IDLE: state_d = HDR;
      HDR: if (acc && bcnt_q == 2'd3) begin
        n_d     = shifted;
        state_d = (shifted == 32'd0 || shifted > 32'(MAX_WORDS)) ? ERR : DATA;
      end
      DATA: if (acc) begin
        csum_d = csum_q ^ s_data_i;
        if (bcnt_q == 2'd3) begin
          we_d    = 1'b1;
          addr_d  = wl_q[ADDR_W-1:0];
          wdata_d = shifted;
          wl_d    = wl_q + 1'b1;
          state_d = (32'(wl_q) + 32'd1 == n_q) ? CSUM : DATA;
        end
      end
      CSUM: if (acc) state_d = (s_data_i == csum_q) ? DONE : ERR;
      default: ;
    endcase
    done_d = done_q | (state_d == DONE);
    err_d  = err_q | (state_d == ERR);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
      n_q     <= '0;
      sh_q    <= '0;
      csum_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wl_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      n_q     <= n_d;
      sh_q    <= sh_d;
      csum_q  <= csum_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wl_q    <= wl_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: directed and randomized image loads checked against a word-level image model
module tb_imem_boot_loader;
  localparam int ADDR_W = 10;
  localparam int MAX_WORDS = 1024;
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              s_valid = 1'b0;
  logic [7:0]        s_data = 8'h00;
  logic              s_ready, imem_we, core_rst, done, err;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   words_ld;
  int checks = 0;
  int errors = 0;
  logic [31:0] pay[$];
  logic [31:0] act_a[$];
  logic [31:0] act_d[$];
  imem_boot_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid_i(s_valid), .s_data_i(s_data), .s_ready_o(s_ready),
    .imem_we_o(imem_we), .imem_addr_o(imem_addr), .imem_wdata_o(imem_wdata),
    .core_rst_o(core_rst), .done_o(done), .err_o(err), .words_ld_o(words_ld)
  );
  always #5 clk = ~clk;
  task automatic chk(input logic [63:0] got, input logic [63:0] exp, input string tag);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n) begin
      chk(64'(done & err), 64'd0, "done_err_exclusive");
      chk(64'(core_rst), 64'(done), "core_rst_tracks_done");
    end
    if (imem_we) begin
      act_a.push_back(32'(imem_addr));
      act_d.push_back(imem_wdata);
      chk(64'(words_ld), 64'(imem_addr) + 64'd1, "words_ld_at_write");
    end
  end
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    s_valid = 1'b0;
    #1;
    chk({s_ready, imem_we, core_rst, done, err}, 64'd0, "rst_flags");
    chk({32'(imem_addr), imem_wdata}, 64'd0, "rst_addr_data");
    chk(64'(words_ld), 64'd0, "rst_words_ld");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    act_a.delete();
    act_d.delete();
  endtask
  task automatic send(input logic [7:0] b, input int maxgap);
    int t;
    repeat ($urandom_range(0, maxgap)) begin
      @(negedge clk);
      s_valid = 1'b0;
      s_data = 8'($urandom);
    end
    @(negedge clk);
    s_valid = 1'b1;
    s_data = b;
    t = 0;
    while (!s_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready) chk(64'(s_ready), 64'd1, "accept_timeout");
  endtask
  task automatic load(input logic [31:0] n, input bit bad, input int maxgap);
    logic [7:0] x;
    bit hdr_ok;
    logic [31:0] w;
    x = 8'h00;
    hdr_ok = (n != 0) && (n <= MAX_WORDS);
    for (int i = 0; i < 4; i++) send(n[8*i +: 8], maxgap);
    if (!hdr_ok) begin
      @(posedge clk);
      #1;
      chk(64'(err), 64'd1, "hdr_err_next_cycle");
    end else begin
      for (int i = 0; i < int'(n); i++) begin
        w = pay[i];
        for (int b = 0; b < 4; b++) send(w[8*b +: 8], maxgap);
        x = x ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
      end
      send(bad ? x ^ 8'h01 : x, maxgap);
      @(posedge clk);
      #1;
      chk({done, err}, bad ? 64'b01 : 64'b10, "csum_result_next_cycle");
    end
    @(negedge clk);
    s_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk(64'(act_a.size()), hdr_ok ? 64'(n) : 64'd0, "write_count");
    if (hdr_ok && act_a.size() == int'(n))
      for (int i = 0; i < int'(n); i++) begin
        chk(64'(act_a[i]), 64'(i), "write_addr");
        chk(64'(act_d[i]), 64'(pay[i]), "write_data");
      end
    chk({done, err, core_rst, s_ready}, (hdr_ok && !bad) ? 64'b1010 : 64'b0100, "final_flags");
    chk(64'(words_ld), hdr_ok ? 64'(n) : 64'd0, "final_words_ld");
  endtask
  task automatic rand_pay(input int n);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back($urandom);
  endtask
  initial begin
    #1;
    chk({s_ready, imem_we, core_rst, done, err}, 64'd0, "init_rst_flags");
    chk(64'(words_ld), 64'd0, "init_words_ld");
    pay = '{32'h00500093, 32'h00100113};
    do_reset();
    load(2, 1'b0, 0);
    do_reset();
    load(2, 1'b1, 0);
    do_reset();
    load(0, 1'b0, 0);
    do_reset();
    load(MAX_WORDS + 1, 1'b0, 0);
    rand_pay(MAX_WORDS);
    do_reset();
    load(MAX_WORDS, 1'b0, 0);
    chk(64'(act_a.size() > 0 ? act_a[act_a.size()-1] : 32'hFFFF_FFFF), 64'h3FF, "last_addr_max");
    pay = '{32'h00500093, 32'h00100113};
    do_reset();
    load(2, 1'b0, 3);
    do_reset();
    for (int i = 0; i < 4; i++) send(i == 0 ? 8'd2 : 8'd0, 0);
    for (int b = 0; b < 5; b++) send(8'(pay[b/4] >> (8*(b%4))), 0);
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    chk(64'(act_a.size()), 64'd1, "partial_write_count");
    if (act_a.size() == 1) chk({act_a[0], act_d[0]}, {32'd0, 32'h00500093}, "partial_write");
    do_reset();
    load(2, 1'b0, 0);
    for (int k = 0; k < 6; k++) begin
      rand_pay(int'($urandom_range(1, 8)));
      do_reset();
      load(pay.size(), 1'($urandom), 3);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
